dec_scheduler: RTL

Front-end controller for the decryption datapath. It accepts an input byte stream of terminated messages, each tagged with an algorithm code on its first byte, and routes the bytes to the Caesar, Scytale or ZigZag decryptor. It drives the output mux `select` and holds it stable until the active decryptor has drained, so that messages never interleave at the system output.

---
 rtl/dec_scheduler_pkg.sv | 37 +++
 rtl/dec_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dec_scheduler_pkg.sv
// Shared definitions for the decryption front-end scheduler: algorithm codes,
// the default terminator byte, FSM state encodings and small helpers.
package dec_scheduler_pkg;

  localparam logic [1:0] ALG_CAESAR  = 2'd0;
  localparam logic [1:0] ALG_SCYTALE = 2'd1;
  localparam logic [1:0] ALG_ZIGZAG  = 2'd2;
  localparam logic [1:0] ALG_INVALID = 2'd3;

  localparam logic [7:0] TERM_DEFAULT = 8'hFA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FWD     = 3'd1,
    DRAIN   = 3'd2,
    FLUSH   = 3'd3,
    DISCARD = 3'd4
  } state_e;

  // One-hot decryptor strobe for an algorithm code; the invalid code maps to none.
  function automatic logic [2:0] alg_onehot(input logic [1:0] alg);
    logic [2:0] oh;
    oh = 3'b000;
    case (alg)
      ALG_CAESAR:  oh = 3'b001;
      ALG_SCYTALE: oh = 3'b010;
      ALG_ZIGZAG:  oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/dec_scheduler.sv
// Routes terminated, algorithm-tagged messages to one of three decryptors and
// holds the output mux select until the chosen decryptor has drained.
module dec_scheduler
  import dec_scheduler_pkg::*;
#(
  parameter int                 D_WIDTH = 8,
  parameter logic [D_WIDTH-1:0] TERM    = D_WIDTH'(TERM_DEFAULT),
  parameter int                 MAX_LEN = 64,
  localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         alg_i,
  output logic               busy_o,
  output logic [D_WIDTH-1:0] data_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  input  logic [2:0]         busy_i,
  output logic [1:0]         select_o,
  output logic               err_o,
  output logic               done_o,
  output logic [LEN_W-1:0]   len_o
);

  state_e             state_q, state_d;
  logic [1:0]         select_q, select_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         res_q, res_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [2:0]         vld_q, vld_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               busy_q, busy_d;
  logic               sel_busy;

  always_comb begin
    sel_busy = 1'b0;
    case (select_q)
      ALG_CAESAR:  sel_busy = busy_i[0];
      ALG_SCYTALE: sel_busy = busy_i[1];
      ALG_ZIGZAG:  sel_busy = busy_i[2];
      default:     sel_busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    res_d    = res_q;
    data_d   = data_q;
    vld_d    = 3'b000;
    err_d    = 1'b0;
    done_d   = 1'b0;
    len_d    = len_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          select_d = alg_i;
          cnt_d    = LEN_W'(1);
          if (alg_i == ALG_INVALID) begin
            err_d   = 1'b1;
            state_d = (data_i == TERM) ? IDLE : DISCARD;
          end else begin
            data_d = data_i;
            vld_d  = alg_onehot(alg_i);
            if (data_i == TERM) begin
              state_d = DRAIN;
              res_d   = 2'd1;
            end else begin
              state_d = FWD;
            end
          end
        end
      end

      FWD: begin
        if (valid_i) begin
          cnt_d  = cnt_q + LEN_W'(1);
          data_d = data_i;
          vld_d  = alg_onehot(select_q);
          if (data_i == TERM) begin
            state_d = DRAIN;
            res_d   = 2'd1;
          end else if (cnt_d == LEN_W'(MAX_LEN)) begin
            // Over-long message: close it with a synthetic terminator, drop the rest later
            data_d  = TERM;
            err_d   = 1'b1;
            ovf_d   = 1'b1;
            state_d = DRAIN;
            res_d   = 2'd1;
          end
        end
      end

      DRAIN: begin
        res_d = sat_inc2(res_q);
        if (res_q >= 2'd2 && !sel_busy) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        done_d = 1'b1;
        len_d  = cnt_q;
        if (ovf_q) begin
          ovf_d   = 1'b0;
          state_d = DISCARD;
        end else begin
          state_d = IDLE;
        end
      end

      DISCARD: begin
        if (valid_i && data_i == TERM) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRAIN) || (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      select_q <= 2'd0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      res_q    <= 2'd0;
      data_q   <= '0;
      vld_q    <= 3'b000;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      res_q    <= res_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      done_q   <= done_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign data_o   = data_q;
  assign valid0_o = vld_q[0];
  assign valid1_o = vld_q[1];
  assign valid2_o = vld_q[2];
  assign select_o = select_q;
  assign err_o    = err_q;
  assign done_o   = done_q;
  assign len_o    = len_q;

endmodule
